// File: rtl/rr_search_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : rr_search_arbiter_if
//  Description : Request / grant bundle between request sources, the
//                rr_search_arbiter and the consumer of the shared port.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rr_search_arbiter_if #(
  parameter int ENTNUM = 4,
  parameter int ENTSEL = 2
);

  logic [ENTNUM-1:0] req;
  logic              mode;
  logic              lock;
  logic              gnt_ready;
  logic              gnt_valid;
  logic [ENTSEL-1:0] gnt_idx;
  logic [ENTNUM-1:0] gnt_onehot;

  // Requester / consumer side: raises requests and accepts grants.
  modport master (
    output req,
    output mode,
    output lock,
    output gnt_ready,
    input  gnt_valid,
    input  gnt_idx,
    input  gnt_onehot
  );

  // Arbiter side: observes requests and presents the grant.
  modport slave (
    input  req,
    input  mode,
    input  lock,
    input  gnt_ready,
    output gnt_valid,
    output gnt_idx,
    output gnt_onehot
  );

endinterface
`default_nettype wire

// File: rtl/rr_search_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_search_arbiter
//  Description : Registered request arbiter. Picks one winner out of ENTNUM
//                requests either by fixed lowest-index priority or by a
//                round-robin scan starting one past the last served index.
//                The grant is held under a valid/ready handshake and can be
//                locked onto one requester across beats.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_search_arbiter #(
  parameter int ENTNUM = 4,
  parameter int ENTSEL = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rr_search_arbiter_if.slave   bus
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  if (ENTNUM < 2 || ENTNUM > 64) begin : g_bad_entnum
    $error("rr_search_arbiter: ENTNUM=%0d outside legal range 2..64", ENTNUM);
  end

  if (ENTSEL < $clog2(ENTNUM)) begin : g_bad_entsel
    $error("rr_search_arbiter: ENTSEL=%0d too narrow for ENTNUM=%0d", ENTSEL, ENTNUM);
  end

  localparam logic [ENTSEL-1:0] LAST_IDX = ENTSEL'(ENTNUM - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  // First set request found when scanning ENTNUM positions upward from base,
  // wrapping modulo ENTNUM. Iterating from the far end down lets the nearest
  // hit overwrite later ones, so no early exit is needed.
  function automatic logic [ENTSEL-1:0] search_first(
    input logic [ENTNUM-1:0] r,
    input logic [ENTSEL-1:0] base
  );
    logic [ENTSEL-1:0] win;
    int                pos;
    win = '0;
    for (int i = ENTNUM - 1; i >= 0; i--) begin
      pos = int'(base) + i;
      if (pos >= ENTNUM) pos = pos - ENTNUM;
      if (r[pos]) win = ENTSEL'(pos);
    end
    return win;
  endfunction

  function automatic logic [ENTNUM-1:0] to_onehot(input logic [ENTSEL-1:0] idx);
    return {{(ENTNUM-1){1'b0}}, 1'b1} << idx;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t            state;
  logic [ENTSEL-1:0] ptr;
  logic              valid_q;
  logic [ENTSEL-1:0] idx_q;
  logic [ENTNUM-1:0] onehot_q;

  logic [ENTSEL-1:0] ptr_next;
  logic [ENTSEL-1:0] base_idle;
  logic [ENTSEL-1:0] base_hs;
  logic [ENTSEL-1:0] win_idle;
  logic [ENTSEL-1:0] win_hs;
  logic              any_req;
  logic              held_req;

  // Candidate winners for both arbitration points: entering from IDLE uses
  // the stored pointer, a handshake uses the pointer it is about to write.
  always_comb begin
    ptr_next  = (idx_q == LAST_IDX) ? '0 : idx_q + ENTSEL'(1);
    base_idle = bus.mode ? ptr      : '0;
    base_hs   = bus.mode ? ptr_next : '0;
    win_idle  = search_first(bus.req, base_idle);
    win_hs    = search_first(bus.req, base_hs);
    any_req   = |bus.req;
    held_req  = |(bus.req & onehot_q);
  end

  // Arbitration FSM; every output is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      onehot_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            idx_q    <= win_idle;
            onehot_q <= to_onehot(win_idle);
            valid_q  <= 1'b1;
            state    <= GRANT;
          end
        end

        GRANT: begin
          // Without ready the grant is frozen regardless of req/mode/lock.
          if (bus.gnt_ready) begin
            if (bus.lock && held_req) begin
              // Locked beat: same requester again, pointer untouched.
              state <= GRANT;
            end else begin
              ptr <= ptr_next;
              if (any_req) begin
                idx_q    <= win_hs;
                onehot_q <= to_onehot(win_hs);
                valid_q  <= 1'b1;
                state    <= GRANT;
              end else begin
                valid_q  <= 1'b0;
                onehot_q <= '0;
                state    <= IDLE;
              end
            end
          end
        end

        default: begin
          state    <= IDLE;
          valid_q  <= 1'b0;
          onehot_q <= '0;
        end
      endcase
    end
  end

  assign bus.gnt_valid  = valid_q;
  assign bus.gnt_idx    = idx_q;
  assign bus.gnt_onehot = onehot_q;

endmodule
`default_nettype wire

// File: doc/rr_search_arbiter.md
Name: rr_search_arbiter

Overview:
- Registered successor to the combinational lowest-index search encoder.
- Picks one winner from an ENTNUM-wide request vector in one of two modes:
  - fixed priority: lowest set index wins, same result as the legacy encoder;
  - round-robin: search starts one past the last served index.
- The grant is held under a valid/ready handshake until consumed. An optional lock keeps the grant on one requester across beats.
- Sits between request sources (e.g. queue entries) and a shared resource port.

Parameters:
- ENTNUM, 4: number of requesters. Legal range 2..64, any value (not restricted to powers of two).
- ENTSEL, 2: index width. Must be >= clog2(ENTNUM); elaboration error otherwise.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- req, input, ENTNUM: request vector; bit i means requester i wants the resource.
- mode, input, 1: 0 = fixed priority (lowest index first), 1 = round-robin.
- lock, input, 1: while high at a handshake, the current grant is kept for the next beat.
- gnt_ready, input, 1: consumer accepts the current grant this cycle.
- gnt_valid, output, 1: a grant is being presented.
- gnt_idx, output, ENTSEL: index of the granted requester.
- gnt_onehot, output, ENTNUM: one-hot form of gnt_idx; all zero when gnt_valid=0.

Behaviour:
- Reset (rst_n low, takes effect asynchronously):
  - gnt_valid=0, gnt_idx=0, gnt_onehot=0, rr pointer ptr=0, state IDLE.
  - Reset asserted mid-grant drops the grant immediately; no handshake is completed.
- Registers: gnt_valid, gnt_idx, gnt_onehot and ptr (ENTSEL bits). All outputs come straight from flops.
- Search function: scan ENTNUM positions starting at base = (mode ? ptr : 0), wrapping modulo ENTNUM. The first set req bit wins.
- States:
  - IDLE:
    - req==0: stay in IDLE.
    - req!=0: load the winner into gnt_idx/gnt_onehot, set gnt_valid=1 and go to GRANT.
    - Latency is 1 cycle from req to gnt_valid.
  - GRANT:
    - gnt_ready=0: hold gnt_idx, gnt_onehot and gnt_valid stable. Changes on req, mode or lock are ignored.
    - Handshake (gnt_ready=1) with lock=1 and req[gnt_idx]=1: keep the same grant and stay in GRANT. ptr is unchanged.
    - Handshake, otherwise:
      - Set ptr <= (gnt_idx==ENTNUM-1) ? 0 : gnt_idx+1. ptr is updated in both modes; it only has an effect in mode 1.
      - Re-run the search in the same cycle on the current req, using the updated ptr as base when mode=1.
      - If any req is set, load the new winner with gnt_valid=1 (back-to-back grants, no bubble). If req==0, clear gnt_valid/gnt_onehot and go to IDLE.
- Ordering of events:
  - mode is sampled only at arbitration points (IDLE entry with a request, or a non-locked handshake).
  - If req[gnt_idx] drops before the handshake, the grant still stands until gnt_ready. Withdrawing a request is a source protocol error; the arbiter does not check for it.
  - Under fixed priority, a continuously asserted low index starves higher indices. This is intended legacy behaviour.
  - Under round-robin, each continuously requesting index is granted at least once per ENTNUM non-locked handshakes.
- Non-power-of-two ENTNUM: ptr and the wrap both compare against ENTNUM-1, so ptr never holds a value >= ENTNUM.
- gnt_onehot always equals (1 << gnt_idx) when gnt_valid=1.

Test Plan:
- Reset then fixed priority: mode=0, req=4'b1010, gnt_ready=1 held → gnt_valid rises 1 cycle later with gnt_idx=1. Grants 1,1,1… every cycle.
- Round-robin fairness: mode=1, req=4'b1111 constant, gnt_ready=1 → gnt_idx sequence 0,1,2,3,0,1, with gnt_valid continuously 1.
- Backpressure: mode=1, req=4'b0110, gnt_ready=0 for 5 cycles with req changed to 4'b0001 at cycle 3 → gnt_idx=1 stable throughout. After ready, next grant is idx 0.
- Lock: mode=1, req=4'b1001, first grant idx 0 with lock=1 for 3 handshakes → idx 0 granted 4 times. lock=0 then gives idx 3.
- Drain to idle: single req=4'b0100 pulse held until handshake, then req=0 → one grant idx 2, then gnt_valid=0, gnt_onehot=0, ptr=3. A new req=4'b1000 grants idx 3 after 1 cycle.
- Async reset mid-grant and non-power-of-two: ENTNUM=5, ENTSEL=3, req=5'b10000 → grant idx 4, ptr wraps to 0 after the handshake. rst_n pulsed low while gnt_valid=1 → gnt_valid=0 before the next clk edge.
